// File: rtl/set_mode_ctrl_pkg.sv
// Shared front-panel definitions for the century clock: controller states and
// the field codes also decoded by the 7-segment display selector.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN_TIME,
    RUN_DATE,
    ED_HOUR,
    ED_MIN,
    ED_SEC,
    ED_DAY,
    ED_MONTH,
    ED_YEAR
  } ctrl_state_t;

  localparam logic [2:0] BLINK_NONE  = 3'b000;
  localparam logic [2:0] BLINK_SEC   = 3'b001;
  localparam logic [2:0] BLINK_MIN   = 3'b010;
  localparam logic [2:0] BLINK_HOUR  = 3'b011;
  localparam logic [2:0] BLINK_DAY   = 3'b100;
  localparam logic [2:0] BLINK_MONTH = 3'b101;
  localparam logic [2:0] BLINK_YEAR  = 3'b110;

  function automatic logic [2:0] field_code(ctrl_state_t s);
    case (s)
      ED_HOUR:  return BLINK_HOUR;
      ED_MIN:   return BLINK_MIN;
      ED_SEC:   return BLINK_SEC;
      ED_DAY:   return BLINK_DAY;
      ED_MONTH: return BLINK_MONTH;
      ED_YEAR:  return BLINK_YEAR;
      default:  return BLINK_NONE;
    endcase
  endfunction

  function automatic logic is_time_view(ctrl_state_t s);
    return (s == RUN_TIME) || (s == ED_HOUR) || (s == ED_MIN) || (s == ED_SEC);
  endfunction

  function automatic logic is_edit(ctrl_state_t s);
    return (s != RUN_TIME) && (s != RUN_DATE);
  endfunction

endpackage

// File: rtl/set_mode_ctrl_blink_gen.sv
// Blink prescaler: divides clk down to a half-period phase flag for blanking
// the digits under edit. A clear restarts the visible half-period.
module blink_gen #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic phase
);

  localparam int CW = $clog2(BLINK_HALF);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (en) begin
      if (r_cnt == CW'(BLINK_HALF - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/set_mode_ctrl.sv
// Front-panel control FSM: maps debounced button pulses to view/field-select
// outputs for the display and inc/dec strobes plus hold for the counters.
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF = 25_000_000,
  parameter int TIMEOUT    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       mode,
  output logic [2:0] blink_mode,
  output logic       tick_blink,
  output logic       edit_active,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  localparam int TO_W = $clog2(TIMEOUT);

  ctrl_state_t     r_state;
  logic            r_mode;
  logic [2:0]      r_blink;
  logic            r_edit;
  logic            r_inc;
  logic            r_dec;
  logic [TO_W-1:0] r_to;

  ctrl_state_t     w_next;
  logic            w_any;
  logic            w_timeout;
  logic            w_enter_ed;
  logic            w_accept;
  logic            w_phase;

  // Priority: mode beats set, set beats timeout; up/down never move the state.
  function automatic ctrl_state_t next_state(ctrl_state_t s, logic m, logic st, logic tmo);
    ctrl_state_t n;
    n = s;
    if (m) begin
      if (s == RUN_TIME)     n = RUN_DATE;
      else if (s == RUN_DATE) n = RUN_TIME;
      else                    n = is_time_view(s) ? RUN_TIME : RUN_DATE;
    end else if (st) begin
      case (s)
        RUN_TIME: n = ED_HOUR;
        ED_HOUR:  n = ED_MIN;
        ED_MIN:   n = ED_SEC;
        ED_SEC:   n = RUN_TIME;
        RUN_DATE: n = ED_DAY;
        ED_DAY:   n = ED_MONTH;
        ED_MONTH: n = ED_YEAR;
        default:  n = RUN_DATE;
      endcase
    end else if (tmo) begin
      n = is_time_view(s) ? RUN_TIME : RUN_DATE;
    end
    return n;
  endfunction

  assign w_any      = btn_mode | btn_set | btn_up | btn_down;
  assign w_timeout  = r_edit & (r_to == TO_W'(TIMEOUT - 1)) & ~w_any;
  assign w_next     = next_state(r_state, btn_mode, btn_set, w_timeout);
  assign w_enter_ed = is_edit(w_next) & (w_next != r_state);
  assign w_accept   = r_edit & ~btn_mode & ~btn_set & (btn_up ^ btn_down);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN_TIME;
      r_mode  <= 1'b1;
      r_blink <= BLINK_NONE;
      r_edit  <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mode  <= is_time_view(w_next);
      r_blink <= field_code(w_next);
      r_edit  <= is_edit(w_next);
      r_inc   <= w_accept & btn_up;
      r_dec   <= w_accept & btn_down;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to <= '0;
    end else if (w_any || w_enter_ed || !is_edit(w_next)) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_enter_ed | w_accept),
    .en    (r_edit),
    .phase (w_phase)
  );

  assign mode        = r_mode;
  assign blink_mode  = r_blink;
  assign tick_blink  = w_phase & r_edit;
  assign edit_active = r_edit;
  assign inc_pulse   = r_inc;
  assign dec_pulse   = r_dec;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a view/position/elapsed-time reference model.
module tb_set_mode_ctrl;

  localparam int BH = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_set, btn_up, btn_down;
  logic       mode;
  logic [2:0] blink_mode;
  logic       tick_blink, edit_active, inc_pulse, dec_pulse;

  set_mode_ctrl #(
    .BLINK_HALF(BH),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_set    (btn_set),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .mode       (mode),
    .blink_mode (blink_mode),
    .tick_blink (tick_blink),
    .edit_active(edit_active),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: view flag, position in the 3-field edit chain (0 = not
  // editing), cycles since last blink restart, idle cycles in edit.
  bit m_time;
  int m_pos;
  int m_k;
  int m_idle;
  bit m_inc, m_dec;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time = 1; m_pos = 0; m_k = 0; m_idle = 0; m_inc = 0; m_dec = 0;
  endtask

  task automatic model_step(input bit m, input bit s, input bit u, input bit d);
    int  old_pos;
    bit  restart;
    old_pos = m_pos;
    restart = 0;
    m_inc = 0; m_dec = 0;
    if (m) begin
      if (m_pos == 0) m_time = !m_time;
      else m_pos = 0;
    end else if (s) begin
      m_pos = (m_pos == 3) ? 0 : m_pos + 1;
      if (m_pos != 0) restart = 1;
    end else if (m_pos != 0 && (u != d)) begin
      m_inc = u; m_dec = d; restart = 1;
    end else if (m_pos != 0 && !u && !d && m_idle == TO - 1) begin
      m_pos = 0;
    end
    if (m || s || u || d || m_pos == 0) m_idle = 0;
    else m_idle = m_idle + 1;
    if (restart) m_k = 0;
    else if (old_pos != 0) m_k = m_k + 1;
  endtask

  function automatic logic [7:0] model_vec();
    logic [2:0] code;
    logic       tick;
    if (m_pos == 0) code = 3'd0;
    else if (m_time) code = 3'(4 - m_pos);
    else code = 3'(3 + m_pos);
    tick = (m_pos != 0) && (((m_k / BH) % 2) == 1);
    return {m_time, code, tick, (m_pos != 0), m_inc, m_dec};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {mode, blink_mode, tick_blink, edit_active, inc_pulse, dec_pulse};
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
  task automatic cyc(input bit m, input bit s, input bit u, input bit d);
    btn_mode = m; btn_set = s; btn_up = u; btn_down = d;
    @(posedge clk);
    model_step(m, s, u, d);
    #1;
    check_val("cycle", 32'(dut_vec()), 32'(model_vec()));
    btn_mode = 0; btn_set = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_mode = 0; btn_set = 0; btn_up = 0; btn_down = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 32'(dut_vec()), 32'(8'b1_000_0_0_0_0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(50);
    check_val("idle_outputs", 32'(dut_vec()), 32'(8'b1_000_0_0_0_0));

    // Date view, walk the date edit chain back to RUN_DATE.
    cyc(1, 0, 0, 0);
    check_val("view_date", 32'(mode), 32'(0));
    cyc(0, 1, 0, 0); check_val("ed_day", 32'(blink_mode), 32'(3'b100));
    cyc(0, 1, 0, 0); check_val("ed_month", 32'(blink_mode), 32'(3'b101));
    cyc(0, 1, 0, 0); check_val("ed_year", 32'(blink_mode), 32'(3'b110));
    cyc(0, 1, 0, 0); check_val("run_date", 32'(blink_mode), 32'(3'b000));
    check_val("run_date_mode", 32'(mode), 32'(0));

    // Time view, ED_MIN with three back-to-back increments.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      check_val("inc_burst", 32'({inc_pulse, blink_mode}), 32'({1'b1, 3'b010}));
    end
    idle(14);
    cyc(0, 0, 0, 1);
    check_val("dec_strobe", 32'({dec_pulse, inc_pulse}), 32'(2'b10));

    // Abort, re-enter ED_HOUR; set beats up, up+down cancel.
    cyc(1, 0, 0, 0);
    check_val("abort_run_time", 32'({mode, edit_active}), 32'(2'b10));
    cyc(0, 1, 0, 0);
    check_val("ed_hour", 32'(blink_mode), 32'(3'b011));
    cyc(0, 1, 1, 0);
    check_val("set_beats_up", 32'({blink_mode, inc_pulse}), 32'({3'b010, 1'b0}));
    cyc(0, 0, 1, 1);
    check_val("up_down_cancel", 32'({inc_pulse, dec_pulse}), 32'(0));
    cyc(1, 0, 1, 0);
    check_val("mode_beats_up", 32'({edit_active, inc_pulse}), 32'(0));
    cyc(0, 0, 1, 0);
    check_val("run_ignores_up", 32'(inc_pulse), 32'(0));

    // Timeout out of ED_YEAR.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= TO; i++) begin
      cyc(0, 0, 0, 0);
      if (i == TO - 1) check_val("timeout_pre", 32'({edit_active, blink_mode}), 32'({1'b1, 3'b110}));
      if (i == TO) check_val("timeout_exit", 32'({edit_active, blink_mode, mode}), 32'(0));
    end

    // Asynchronous reset in the middle of ED_DAY.
    cyc(0, 1, 0, 0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", 32'(dut_vec()), 32'(8'b1_000_0_0_0_0));
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check_val("reset_release", 32'(dut_vec()), 32'(8'b1_000_0_0_0_0));
    cyc(0, 1, 0, 0);
    check_val("post_reset_hour", 32'(blink_mode), 32'(3'b011));

    // Random traffic with periodic quiet spells to reach the timeout.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 300) == 299) idle(TO + 3);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_mode_ctrl.md
# set_mode_ctrl

Front-panel control FSM for the century clock: turns debounced push-button pulses into the `mode`, `blink_mode` and `tick_blink` controls consumed by the 7-segment display selector, plus the increment/decrement strobes and hold flag used by the time/date counters. It owns the view (time or date), which field is being edited, the blink timing and the edit timeout.

## Interface
- `BLINK_HALF`, default 25_000_000: clk cycles per blink half-period (0.5 s at 50 MHz); must be ≥ 2.
- `TIMEOUT`, default 500_000_000: idle clk cycles in an edit state before the FSM auto-exits; must be ≥ 2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_mode`  in  1  one-cycle pulse: toggle view, or abort an edit.
- `btn_set`  in  1  one-cycle pulse: enter edit, or advance to the next field.
- `btn_up`  in  1  one-cycle pulse: increment the selected field.
- `btn_down`  in  1  one-cycle pulse: decrement the selected field.
- `mode`  out  1  1 = time view (HH MM SS), 0 = date view (DD MM YYYY).
- `blink_mode`  out  3  selected field code (below); 000 = none.
- `tick_blink`  out  1  1 = blank the selected digits this half-period.
- `edit_active`  out  1  1 in any edit state; counters hold while high.
- `inc_pulse`  out  1  one-cycle increment strobe for the field in `blink_mode`.
- `dec_pulse`  out  1  one-cycle decrement strobe for the field in `blink_mode`.

## Operation
- Field codes: SEC=001, MIN=010, HOUR=011, DAY=100, MONTH=101, YEAR=110; 111 is never driven.
- States: RUN_TIME, RUN_DATE, ED_HOUR, ED_MIN, ED_SEC, ED_DAY, ED_MONTH, ED_YEAR.
- RUN_TIME: `btn_mode` → RUN_DATE; `btn_set` → ED_HOUR. RUN_DATE: `btn_mode` → RUN_TIME; `btn_set` → ED_DAY.
- `btn_set` chain: ED_HOUR → ED_MIN → ED_SEC → RUN_TIME, and ED_DAY → ED_MONTH → ED_YEAR → RUN_DATE.
- In any ED state, `btn_mode` aborts to the RUN state of the same view. Edits already applied are kept.
- In RUN states, `btn_up` and `btn_down` are ignored.
- `mode` = 1 in RUN_TIME and ED_HOUR/MIN/SEC; 0 otherwise. `blink_mode` = field code of the ED state, 000 in RUN states.
- Button priority in one cycle: `btn_mode` > `btn_set` > up/down. Up and down together are both ignored.
- An up/down pulse that loses to `btn_mode` or `btn_set` is dropped.
- Blink prescaler:
  - counts 0..BLINK_HALF-1; at wrap it toggles `blink_phase`.
  - `tick_blink` = `blink_phase` & `edit_active`.
  - The prescaler and phase clear to 0 on entry to any ED state and on every accepted up/down, so the digits stay visible for a full half-period after each press.
- Timeout counter:
  - clears on any button pulse and on entry to an ED state; increments every cycle while in an ED state.
  - Reaching TIMEOUT-1 forces the RUN state of the current view on the next edge. This has lower priority than any button in the same cycle.

## Timing
- Reset (async assert, sync release): state RUN_TIME; `mode`=1, `blink_mode`=000, `tick_blink`=0, `edit_active`=0, `inc_pulse`=0, `dec_pulse`=0. Prescaler, phase and timeout counter are 0.
- All outputs are registered; there is no combinational path from the buttons.
- A button pulse sampled at edge N takes effect from edge N: outputs change after edge N and are valid for cycle N+1.
- An accepted up/down at edge N gives `inc_pulse`/`dec_pulse` high for exactly cycle N+1. `blink_mode` is unchanged, so the strobe and the field code are coherent.
- Back-to-back up pulses on consecutive cycles give back-to-back strobes; no pulse is lost.
- `rst_n` asserted mid-edit returns the block to RUN_TIME immediately. No strobe is emitted.

## Structure
- Shared package `clock_pkg`: state enum `ctrl_state_t` and the six `BLINK_*` field-code localparams. The display selector uses the same codes.
- One sub-module, `blink_gen`: the prescaler plus phase flip-flop, with `clr` and `en` inputs and a `phase` output. The FSM and the timeout counter stay in `set_mode_ctrl`.
- Counter widths are `$clog2(BLINK_HALF)` and `$clog2(TIMEOUT)`.

## Test plan
All scenarios use BLINK_HALF=4 and TIMEOUT=20.
- Reset, then idle 50 cycles → `mode`=1, `blink_mode`=000, `tick_blink`=0, no strobes.
- `btn_mode`, then `btn_set` ×4 → `mode` goes to 0; `blink_mode` steps 100, 101, 110, 000; `mode` stays 0 throughout.
- In ED_MIN, `btn_up` on 3 consecutive cycles → `inc_pulse` high for 3 consecutive cycles with `blink_mode`=010. The following 4 cycles have `tick_blink`=0, then it toggles every 4 cycles.
- In ED_HOUR, `btn_set` and `btn_up` in the same cycle → state ED_MIN (`blink_mode`=010), no `inc_pulse`. `btn_up` and `btn_down` together → no strobe.
- In ED_YEAR with no buttons → exactly 20 cycles after entry, `blink_mode`=000, `edit_active`=0, `mode`=0.
- `rst_n` low for 1 cycle mid-ED_DAY (async, between edges) → outputs return to reset values at once; after release, `btn_set` enters ED_HOUR (`blink_mode`=011).
